// File: rtl/sdram_port_arbiter.sv
// Two-master SDRAM port arbiter: m0 preferred, m1 guaranteed a grant after MAX_STREAK m0 wins.
// Latency: grant 1 cycle after valid; completion pulse 1 cycle after s_ready; masters stall until their pulse.
module sdram_port_arbiter #(
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t     state;
  logic [3:0] streak;
  logic       pick_m1;

  // m1 wins outright when alone, or when m0 has used up its allowed streak
  always_comb begin
    pick_m1 = m1_valid && (!m0_valid || (streak == 4'(MAX_STREAK)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      streak   <= '0;
      s_valid  <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
      grant    <= 2'b00;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid || m1_valid) begin
            state   <= BUSY;
            s_valid <= 1'b1;
            grant   <= pick_m1 ? 2'b10 : 2'b01;
            s_addr  <= pick_m1 ? m1_addr  : m0_addr;
            s_wdata <= pick_m1 ? m1_wdata : m0_wdata;
            s_wstrb <= pick_m1 ? m1_wstrb : m0_wstrb;
            if (pick_m1 || !m1_valid)
              streak <= '0;
            else if (streak != 4'(MAX_STREAK))
              streak <= streak + 4'd1;
          end
        end
        BUSY: begin
          if (s_ready) begin
            state   <= RESP;
            s_valid <= 1'b0;
            if (grant[1]) begin
              m1_rdata <= s_rdata;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= s_rdata;
              m0_ready <= 1'b1;
            end
          end
        end
        RESP: begin
          state    <= IDLE;
          grant    <= 2'b00;
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: predicted grants are queued by stimulus and checked
// by a controller model; returned read data is queued by that model and checked at each ready pulse.
module tb_sdram_port_arbiter;

  localparam int AW = 25;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    bit            owner;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } pred_t;

  typedef struct {
    bit            owner;
    logic [DW-1:0] rdata;
  } resp_t;

  logic          clk;
  logic          rst;
  logic          m0_valid, m1_valid;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [SW-1:0] m0_wstrb, m1_wstrb;
  logic          m0_ready, m1_ready;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic          s_ready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    grant;

  logic          ctl_rdy, spur_rdy, sr_q;
  bit            ctl_active;
  bit            cur_owner;
  int            ctl_cnt, ctl_delay;
  logic [DW-1:0] ctl_data;
  logic [63:0]   lat_req;
  logic [DW-1:0] last0, last1;

  pred_t pred_q[$];
  resp_t resp_q[$];

  int checks;
  int failures;

  assign s_ready = ctl_rdy | spur_rdy;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_pred(input bit who, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
    pred_t p;
    p.owner = who; p.addr = a; p.wdata = d; p.wstrb = s;
    pred_q.push_back(p);
  endtask

  // Controller model: checks each new request against the prediction, holds s_ready off for
  // ctl_delay cycles, then returns ctl_data with a one-cycle s_ready pulse.
  always @(negedge clk) begin
    pred_t p;
    ctl_rdy = 1'b0;
    if (rst) begin
      ctl_active = 0;
    end else begin
      if (!ctl_active && s_valid) begin
        ctl_active = 1;
        ctl_cnt    = 0;
        lat_req    = {3'b0, s_addr, s_wdata, s_wstrb};
        if (pred_q.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          p = pred_q.pop_front();
          cur_owner = p.owner;
          chk("grant", grant, p.owner ? 2'b10 : 2'b01);
          chk("s_addr", s_addr, p.addr);
          chk("s_wdata", s_wdata, p.wdata);
          chk("s_wstrb", s_wstrb, p.wstrb);
        end
      end
      if (ctl_active) begin
        chk("s_valid_held", s_valid, 1);
        chk("s_req_stable", {3'b0, s_addr, s_wdata, s_wstrb}, lat_req);
        ctl_cnt++;
        if (ctl_cnt >= ctl_delay) begin
          ctl_rdy = 1'b1;
          s_rdata = ctl_data;
          resp_q.push_back('{cur_owner, ctl_data});
          ctl_data   = $urandom;
          ctl_active = 0;
        end
      end
    end
  end

  always @(posedge clk) sr_q <= ctl_rdy;

  // Response monitor plus per-cycle grant invariants
  always @(negedge clk) begin
    resp_t r;
    chk("grant_onehot", $countones(grant) <= 1, 1);
    chk("svalid_no_grant", s_valid && (grant == 2'b00), 0);
    if (rst) begin
      last0 = '0;
      last1 = '0;
    end else begin
      if (sr_q || m0_ready || m1_ready)
        chk("ready_latency", m0_ready | m1_ready, sr_q);
      if (m0_ready || m1_ready) begin
        if (resp_q.size() == 0) begin
          chk("spurious_ready", 1, 0);
        end else begin
          r = resp_q.pop_front();
          chk("ready_owner", {m1_ready, m0_ready}, r.owner ? 2'b10 : 2'b01);
          chk("rdata", r.owner ? m1_rdata : m0_rdata, r.rdata);
          chk("other_rdata_kept", r.owner ? m0_rdata : m1_rdata, r.owner ? last0 : last1);
          if (r.owner) last1 = r.rdata;
          else last0 = r.rdata;
        end
      end
    end
  end

  task automatic txn(input bit who, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [SW-1:0] s, input bit spur);
    bit done;
    push_pred(who, a, d, s);
    if (who) begin
      m1_addr = a; m1_wdata = d; m1_wstrb = s; m1_valid = 1'b1;
    end else begin
      m0_addr = a; m0_wdata = d; m0_wstrb = s; m0_valid = 1'b1;
    end
    @(negedge clk);
    chk("req_latency", s_valid, 1);
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (who ? m1_ready : m0_ready) done = 1;
    end
    if (!done) begin
      chk("txn_timeout", 0, 1);
    end else begin
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      chk("resp_grant", grant, who ? 2'b10 : 2'b01);
      spur_rdy = spur;
      @(negedge clk);
      spur_rdy = 1'b0;
      chk("single_pulse", {m1_ready, m0_ready}, 2'b00);
      chk("idle_grant", grant, 2'b00);
      chk("idle_svalid", s_valid, 0);
    end
  endtask

  task automatic both_stream(input int n);
    int cnt;
    cnt = 0;
    m0_addr = 25'h40; m0_wdata = 32'hA5A5_0000; m0_wstrb = 4'hF;
    m1_addr = 25'h80; m1_wdata = 32'h0;         m1_wstrb = 4'h0;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    for (int i = 0; i < 1000 && cnt < n; i++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) cnt++;
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    if (cnt < n) chk("stream_timeout", cnt, n);
  endtask

  task automatic push_stream_pred(input bit who);
    if (who) push_pred(1, 25'h80, 32'h0, 4'h0);
    else push_pred(0, 25'h40, 32'hA5A5_0000, 4'hF);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    ctl_rdy = 1'b0; spur_rdy = 1'b0; ctl_active = 0; ctl_cnt = 0;
    ctl_delay = 2; ctl_data = 32'h0; s_rdata = '0; lat_req = '0; cur_owner = 0;
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    rst = 1'b1; m0_valid = 1'b1; m1_valid = 1'b1;

    // Reset with both masters requesting
    repeat (2) begin
      @(negedge clk);
      chk("rst_svalid", s_valid, 0);
      chk("rst_grant", grant, 2'b00);
      chk("rst_ready", {m1_ready, m0_ready}, 2'b00);
      chk("rst_sreq", {3'b0, s_addr, s_wdata, s_wstrb}, 64'h0);
      chk("rst_rdata", {m1_rdata, m0_rdata}, 64'h0);
    end
    m0_valid = 1'b0; m1_valid = 1'b0; rst = 1'b0;
    @(negedge clk);

    ctl_delay = 5; ctl_data = 32'hDEAD_BEEF;
    txn(0, 25'h100, 32'h0, 4'h0, 0);

    ctl_delay = 3;
    txn(1, 25'h0001FFC, 32'h1234_5678, 4'b0011, 0);

    // Stray s_ready in IDLE, then in RESP
    spur_rdy = 1'b1;
    @(negedge clk);
    spur_rdy = 1'b0;
    chk("spur_idle_svalid", s_valid, 0);
    chk("spur_idle_grant", grant, 2'b00);
    @(negedge clk);
    chk("spur_idle_ready", {m1_ready, m0_ready}, 2'b00);
    ctl_delay = 1;
    txn(0, 25'h200, 32'hCAFE_F00D, 4'hF, 1);
    @(negedge clk);
    chk("spur_resp_svalid", s_valid, 0);

    // Continuous contention: four m0 grants then one m1, twice
    ctl_delay = 2;
    repeat (2) begin
      repeat (4) push_stream_pred(0);
      push_stream_pred(1);
    end
    both_stream(10);
    @(negedge clk);

    // Build streak to 3, reset during the 4th m0 transaction, then expect a fresh streak
    repeat (4) push_stream_pred(0);
    both_stream(3);
    ctl_delay = 30;
    @(negedge clk);
    m0_valid = 1'b1; m1_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_before_rst", s_valid, 1);
    rst = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0;
    @(negedge clk);
    chk("rst_busy_svalid", s_valid, 0);
    chk("rst_busy_grant", grant, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", {m1_ready, m0_ready}, 2'b00);
      chk("post_rst_svalid", s_valid, 0);
    end
    ctl_delay = 2;
    repeat (4) push_stream_pred(0);
    push_stream_pred(1);
    both_stream(5);

    repeat (5) @(negedge clk);
    chk("pred_q_drained", pred_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
